// File: rtl/key_cmd_sched.sv
// Key command scheduler: latches debounced key pulses into pending flags, serialises
// them round-robin into a small command FIFO and hands them out over valid/ready.
module key_cmd_sched #(
   parameter int WIDTH   = 5,
   parameter int CODE_W  = 3,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         key_pulse,
   output logic                     cmd_valid,
   output logic [CODE_W-1:0]        cmd_code,
   input  logic                     cmd_ready,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [7:0]               drop_cnt,
   output logic                     timeout_err,
   output logic                     busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]     WAIT_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
   localparam logic [AW:0]       FULL_LVL  = (AW + 1)'(DEPTH);
   localparam logic [CODE_W-1:0] RR_INIT   = CODE_W'(WIDTH - 1);

   logic [WIDTH-1:0]  pend;
   logic [WIDTH-1:0]  pend_nxt;
   logic [WIDTH-1:0]  cap;
   logic [CODE_W-1:0] rr_ptr;
   logic [CODE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       level;
   logic [AW:0]       level_after_pop;
   logic [TW-1:0]     wait_cnt;
   logic [CODE_W-1:0] code_nxt;

   logic              arb_en;
   logic              grant;
   logic [CODE_W-1:0] grant_idx;
   logic [WIDTH-1:0]  grant_vec;
   logic              push;
   logic              pop;
   logic              to_fire;
   logic              coalesce;

   assign cmd_valid  = (level != '0);
   assign fifo_level = level;
   assign busy       = (|pend) | cmd_valid;

   // Full FIFO blocks the arbiter even when the head pops this cycle.
   assign arb_en = (level != FULL_LVL) && !flush;

   // Pass 1 finds the lowest pending key above the pointer; pass 2 wraps around.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      grant     = 1'b0;
      grant_idx = '0;
      grant_vec = '0;
      if (arb_en) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (!grant && pend[i] && (CODE_W'(i) > rr_ptr)) begin
               grant        = 1'b1;
               grant_idx    = CODE_W'(i);
               grant_vec[i] = 1'b1;
            end
         end
         for (int i = 0; i < WIDTH; i++) begin
            if (!grant && pend[i]) begin
               grant        = 1'b1;
               grant_idx    = CODE_W'(i);
               grant_vec[i] = 1'b1;
            end
         end
      end
   end

   assign push     = grant;
   assign to_fire  = (TIMEOUT > 0) && cmd_valid && !cmd_ready && (wait_cnt == WAIT_LAST);
   assign pop      = cmd_valid && (cmd_ready || to_fire);
   assign cap      = en ? key_pulse : '0;
   assign coalesce = |(cap & pend & ~grant_vec);
   assign pend_nxt = (pend & ~grant_vec) | cap;

   // Registered head: next entry after a pop, or the fresh grant into an empty FIFO.
   always_comb begin
      level_after_pop = level - (AW + 1)'(pop);
      code_nxt        = cmd_code;
      if (level_after_pop != '0)
         code_nxt = mem[rd_ptr + AW'(pop)];
      else if (push)
         code_nxt = grant_idx;
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend        <= '0;
         rr_ptr      <= RR_INIT;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         cmd_code    <= '0;
         drop_cnt    <= '0;
         timeout_err <= 1'b0;
         wait_cnt    <= '0;
      end else if (flush) begin
         pend        <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         timeout_err <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         pend        <= pend_nxt;
         cmd_code    <= code_nxt;
         timeout_err <= to_fire;
         level       <= level + (AW + 1)'(push) - (AW + 1)'(pop);
         if (grant)
            rr_ptr <= grant_idx;
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (coalesce && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
         if ((TIMEOUT == 0) || !cmd_valid || pop)
            wait_cnt <= '0;
         else if (!cmd_ready)
            wait_cnt <= wait_cnt + TW'(1);
      end
   end

   // NOTE: FIFO storage is not reset; the level counter alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= grant_idx;
   end

endmodule

// File: tb/tb_key_cmd_sched.sv
// Scoreboard bench for key_cmd_sched: a default instance for the key path and a
// TIMEOUT=8 instance for the stall-discard behaviour, both driven from the same inputs.
module tb_key_cmd_sched;

   localparam int CODE_W = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       flush = 1'b0;
   logic       cmd_ready = 1'b0;
   logic [4:0] key_pulse = '0;

   logic       cmd_valid, timeout_err, busy;
   logic [2:0] cmd_code, fifo_level;
   logic [7:0] drop_cnt;
   logic       cmd_valid_t, timeout_err_t, busy_t;
   logic [2:0] cmd_code_t, fifo_level_t;
   logic [7:0] drop_cnt_t;

   int n_vec = 0;
   int n_err = 0;
   int sb[$];
   int mon_exp;

   key_cmd_sched dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .key_pulse(key_pulse),
      .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cmd_ready),
      .fifo_level(fifo_level), .drop_cnt(drop_cnt), .timeout_err(timeout_err), .busy(busy)
   );

   key_cmd_sched #(.TIMEOUT(8)) dut_to (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .key_pulse(key_pulse),
      .cmd_valid(cmd_valid_t), .cmd_code(cmd_code_t), .cmd_ready(cmd_ready),
      .fifo_level(fifo_level_t), .drop_cnt(drop_cnt_t), .timeout_err(timeout_err_t), .busy(busy_t)
   );

   always #5 clk = ~clk;

   // Every accepted command on the main instance is matched against the scoreboard.
   always @(negedge clk) begin
      if (!rst && cmd_valid && cmd_ready) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_cmd: got code %0d, expected no command", cmd_code);
         end else begin
            mon_exp = sb.pop_front();
            if (cmd_code !== CODE_W'(mon_exp)) begin
               n_err++;
               $display("FAIL cmd_order: got code %0d, expected %0d", cmd_code, mon_exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      en        = 1'b1;
      flush     = 1'b0;
      key_pulse = '0;
      cmd_ready = 1'b0;
      step();
      step();
      sb.delete();
      rst = 1'b0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      cmd_ready = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         step();
         if (!cmd_valid && sb.size() == 0) done = 1'b1;
      end
      n_vec++;
      if (!done) begin
         n_err++;
         $display("FAIL drain: got %0d pending expected commands, expected 0", sb.size());
      end
      cmd_ready = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_vec++;
      if ({cmd_valid, cmd_code, fifo_level, drop_cnt, timeout_err, busy} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_main: got v=%b c=%0d l=%0d d=%0d e=%b b=%b, expected all 0",
                  cmd_valid, cmd_code, fifo_level, drop_cnt, timeout_err, busy);
      end
      n_vec++;
      if ({cmd_valid_t, cmd_code_t, fifo_level_t, drop_cnt_t, timeout_err_t, busy_t} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_to: got v=%b l=%0d e=%b b=%b, expected all 0",
                  cmd_valid_t, fifo_level_t, timeout_err_t, busy_t);
      end
   endtask

   task automatic test_single_key();
      cmd_ready = 1'b1;
      key_pulse = 5'b00100;
      sb.push_back(2);
      step();
      key_pulse = '0;
      n_vec++;
      if (busy !== 1'b1 || cmd_valid !== 1'b0) begin
         n_err++;
         $display("FAIL single_pend: got busy=%b valid=%b, expected busy=1 valid=0", busy, cmd_valid);
      end
      step();
      n_vec++;
      if (cmd_valid !== 1'b1 || cmd_code !== 3'd2 || fifo_level !== 3'd1) begin
         n_err++;
         $display("FAIL single_out: got valid=%b code=%0d level=%0d, expected 1 2 1",
                  cmd_valid, cmd_code, fifo_level);
      end
      step();
      n_vec++;
      if (cmd_valid !== 1'b0 || fifo_level !== 3'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL single_idle: got valid=%b level=%0d busy=%b, expected 0 0 0",
                  cmd_valid, fifo_level, busy);
      end
      cmd_ready = 1'b0;
   endtask

   task automatic test_simultaneous();
      apply_reset();
      key_pulse = 5'b10011;
      sb.push_back(0);
      sb.push_back(1);
      sb.push_back(4);
      step();
      key_pulse = '0;
      repeat (3) step();
      n_vec++;
      if (fifo_level !== 3'd3 || cmd_code !== 3'd0 || drop_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL simul_fill: got level=%0d head=%0d drop=%0d, expected 3 0 0",
                  fifo_level, cmd_code, drop_cnt);
      end
      drain();
   endtask

   task automatic test_round_robin_full();
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         key_pulse = 5'(1 << k);
         step();
      end
      key_pulse = '0;
      for (int k = 0; k < 4; k++) sb.push_back(k);
      step();
      n_vec++;
      if (fifo_level !== 3'd4 || cmd_code !== 3'd0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL rr_full: got level=%0d head=%0d busy=%b, expected 4 0 1",
                  fifo_level, cmd_code, busy);
      end
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      sb.push_back(4);
      n_vec++;
      if (fifo_level !== 3'd3) begin
         n_err++;
         $display("FAIL rr_no_passthru: got level=%0d, expected 3", fifo_level);
      end
      step();
      n_vec++;
      if (fifo_level !== 3'd4 || cmd_code !== 3'd1) begin
         n_err++;
         $display("FAIL rr_refill: got level=%0d head=%0d, expected 4 1", fifo_level, cmd_code);
      end
      drain();
   endtask

   task automatic test_coalesce();
      apply_reset();
      key_pulse = 5'b10111;
      step();
      key_pulse = '0;
      repeat (4) step();
      sb.push_back(0);
      sb.push_back(1);
      sb.push_back(2);
      sb.push_back(4);
      n_vec++;
      if (fifo_level !== 3'd4) begin
         n_err++;
         $display("FAIL coal_fill: got level=%0d, expected 4", fifo_level);
      end
      key_pulse = 5'b01000;
      step();
      key_pulse = '0;
      step();
      n_vec++;
      if (drop_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL coal_first: got drop=%0d, expected 0", drop_cnt);
      end
      key_pulse = 5'b01000;
      step();
      key_pulse = '0;
      n_vec++;
      if (drop_cnt !== 8'd1) begin
         n_err++;
         $display("FAIL coal_one: got drop=%0d, expected 1", drop_cnt);
      end
      step();
      key_pulse = 5'b01000;
      step();
      key_pulse = '0;
      n_vec++;
      if (drop_cnt !== 8'd2) begin
         n_err++;
         $display("FAIL coal_two: got drop=%0d, expected 2", drop_cnt);
      end
      key_pulse = 5'b01000;
      repeat (300) step();
      key_pulse = '0;
      n_vec++;
      if (drop_cnt !== 8'd255) begin
         n_err++;
         $display("FAIL coal_sat: got drop=%0d, expected 255", drop_cnt);
      end
      sb.push_back(3);
      drain();
   endtask

   task automatic test_timeout();
      apply_reset();
      key_pulse = 5'b00010;
      step();
      key_pulse = '0;
      step();
      n_vec++;
      if (cmd_valid_t !== 1'b1) begin
         n_err++;
         $display("FAIL to_valid: got valid=%b, expected 1", cmd_valid_t);
      end
      repeat (7) step();
      n_vec++;
      if (cmd_valid_t !== 1'b1 || timeout_err_t !== 1'b0) begin
         n_err++;
         $display("FAIL to_early: got valid=%b err=%b in stall cycle 8, expected 1 0",
                  cmd_valid_t, timeout_err_t);
      end
      step();
      n_vec++;
      if (cmd_valid_t !== 1'b0 || timeout_err_t !== 1'b1) begin
         n_err++;
         $display("FAIL to_fire: got valid=%b err=%b, expected 0 1", cmd_valid_t, timeout_err_t);
      end
      step();
      n_vec++;
      if (timeout_err_t !== 1'b0) begin
         n_err++;
         $display("FAIL to_pulse_len: got err=%b, expected 0", timeout_err_t);
      end
      sb.push_back(1);
      key_pulse = 5'b00100;
      sb.push_back(2);
      step();
      key_pulse = '0;
      step();
      repeat (7) step();
      cmd_ready = 1'b1;
      step();
      n_vec++;
      if (cmd_valid_t !== 1'b0 || timeout_err_t !== 1'b0) begin
         n_err++;
         $display("FAIL to_ready_pop: got valid=%b err=%b, expected 0 0", cmd_valid_t, timeout_err_t);
      end
      step();
      n_vec++;
      if (timeout_err_t !== 1'b0) begin
         n_err++;
         $display("FAIL to_ready_err: got err=%b, expected 0", timeout_err_t);
      end
      drain();
   endtask

   task automatic test_enable_flush_reset();
      en        = 1'b0;
      key_pulse = 5'b11111;
      step();
      key_pulse = '0;
      step();
      n_vec++;
      if (busy !== 1'b0 || fifo_level !== 3'd0 || drop_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL en_off: got busy=%b level=%0d drop=%0d, expected 0 0 0",
                  busy, fifo_level, drop_cnt);
      end
      en        = 1'b1;
      key_pulse = 5'b11111;
      step();
      key_pulse = '0;
      repeat (3) step();
      n_vec++;
      if (fifo_level !== 3'd3 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL flush_pre: got level=%0d busy=%b, expected 3 1", fifo_level, busy);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_vec++;
      if (fifo_level !== 3'd0 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flush_clear: got level=%0d busy=%b valid=%b, expected 0 0 0",
                  fifo_level, busy, cmd_valid);
      end
      cmd_ready = 1'b1;
      repeat (5) step();
      cmd_ready = 1'b0;
      key_pulse = 5'b00001;
      step();
      key_pulse = '0;
      repeat (4) step();
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if ({cmd_valid, cmd_code, fifo_level, timeout_err, busy,
           cmd_valid_t, fifo_level_t, timeout_err_t, busy_t} !== 14'h0) begin
         n_err++;
         $display("FAIL rst_mid: got v=%b l=%0d b=%b vt=%b lt=%0d et=%b bt=%b, expected all 0",
                  cmd_valid, fifo_level, busy, cmd_valid_t, fifo_level_t, timeout_err_t, busy_t);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      cmd_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         n_vec++;
         if (timeout_err_t !== 1'b0 || cmd_valid_t !== 1'b0 || cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_replay: got err=%b vt=%b v=%b at cycle %0d, expected 0 0 0",
                     timeout_err_t, cmd_valid_t, cmd_valid, i);
         end
      end
      cmd_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_key();
      test_simultaneous();
      test_round_robin_full();
      test_coalesce();
      test_timeout();
      test_enable_flush_reset();
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL sb_leftover: got %0d outstanding commands, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/key_cmd_sched.md
Name: key_cmd_sched

Overview:
- Sits between the debounced key bank and the drawing/recognition control logic.
- Captures one-cycle debounced key pulses into per-key pending flags.
- Serialises pending keys with a round-robin arbiter into a small command FIFO.
- Presents commands to the consumer over a valid/ready handshake, with a stall timeout so a hung consumer cannot block the key path.

Parameters:
WIDTH, 5, number of keys / pulse inputs
CODE_W, 3, command code width; must satisfy 2^CODE_W >= WIDTH
DEPTH, 4, command FIFO depth; power of two, >= 2
TIMEOUT, 1_000_000, max stall cycles before head command is discarded; 0 disables timeout

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
en  input  1  capture enable; 0 = key pulses ignored
flush  input  1  synchronous clear of pending flags, FIFO and timeout counter
key_pulse  input  WIDTH  one-cycle-high debounced key events; any number of bits may be set in the same cycle
cmd_valid  output  1  FIFO head valid
cmd_code  output  CODE_W  key index of FIFO head
cmd_ready  input  1  consumer accepts head this cycle
fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy
drop_cnt  output  8  saturating count of cycles in which a pulse coalesced into an already-pending key
timeout_err  output  1  one-cycle pulse when the head is discarded by timeout
busy  output  1  any pending flag set or cmd_valid

Behaviour:
- Reset (async, rst=1): pend=0, rr pointer=WIDTH-1, FIFO empty, cmd_valid=0, cmd_code=0, fifo_level=0, drop_cnt=0, timeout_err=0, wait counter=0.
- Capture: when en=1, pend[i] is set for each key_pulse[i]=1. When en=0, pulses are discarded and not counted.
- Same cycle grant of key i plus new pulse on i: pend[i] stays 1 (new event). No drop.
- Pulse on i with pend[i]=1 and not granted: coalesced. drop_cnt +1 once per such cycle regardless of how many keys coalesce. Saturates at 255.
- Arbiter:
  - Runs each cycle while fifo_level < DEPTH.
  - Grants the lowest pending index strictly after the rr pointer, wrapping modulo WIDTH.
  - On grant: index pushed to FIFO, pend cleared, rr pointer <- granted index.
  - At most one grant per cycle.
  - FIFO full: no grant, even if a pop occurs the same cycle (no pass-through).
- Latency: pulse at cycle N -> pend set at N+1 -> push at N+1 -> cmd_valid/cmd_code visible at N+2 (FIFO previously empty, no competing pend).
- FIFO:
  - cmd_valid = (fifo_level != 0); cmd_code = head entry, registered.
  - Pop on cmd_valid && cmd_ready.
  - Simultaneous push and pop: level unchanged.
  - Pointers wrap modulo DEPTH.
  - cmd_code holds its last value when empty; don't-care for checking.
- Timeout (TIMEOUT > 0):
  - Wait counter increments each cycle cmd_valid && !cmd_ready.
  - Clears on pop, on empty, or on flush.
  - When counter == TIMEOUT-1 and cmd_ready=0: head popped (discarded), timeout_err=1 for that cycle's following cycle (registered), counter cleared.
  - cmd_ready=1 in that same cycle: normal pop, no error.
  - TIMEOUT=0: counter held at 0, timeout_err never asserts.
- Flush:
  - Next edge: pend=0, FIFO emptied, wait counter=0, rr pointer unchanged, drop_cnt unchanged.
  - Pulses and grants in the flush cycle are lost.
  - A pop in the flush cycle is not an error.
- busy = (|pend) | cmd_valid, combinational from registers.
- Reset asserted mid-transfer: all state cleared immediately. No command is replayed after release.

Test Plan:
- Single key: key_pulse=5'b00100 at cycle 10, cmd_ready=1 -> cmd_valid=1, cmd_code=2 at cycle 12 for one cycle; fifo_level returns to 0; busy low by cycle 13.
- Simultaneous keys: key_pulse=5'b10011 in one cycle, cmd_ready=0, rr=4 after reset -> FIFO fills with codes 0,1,4 in that order; fifo_level=3; drop_cnt=0.
- Round-robin and full: hold cmd_ready=0, pulse keys 0..4 one per cycle -> FIFO=0,1,2,3 and level=4; pend[4] stays set; then one pop -> code 4 pushed next cycle, not in the pop cycle.
- Coalescing: pulse key 3 twice while FIFO full and pend[3]=1 -> drop_cnt=1 after first repeat, 2 after second; only one code 3 eventually emitted. 300 repeats -> drop_cnt=255.
- Timeout: TIMEOUT=8, one command, cmd_ready=0 -> head discarded after 8 stall cycles; timeout_err high exactly one cycle; cmd_valid=0. Repeat with cmd_ready=1 on the 8th cycle -> normal pop, timeout_err=0.
- Flush/reset/enable:
  - en=0 with pulses -> no pend, drop_cnt unchanged.
  - flush with level=3 and pend set -> next cycle level=0, busy=0.
  - rst pulsed mid-stall -> all outputs at reset values; no timeout_err.
